svx32_dmem_ctrl: RTL and testbench

Data-memory controller directly downstream of the svx32_core memory unit. It accepts the core's single-outstanding request/response handshake (req, wen, addr, wdata, byte_sel) and converts it into accesses on a single-port synchronous SRAM. It inserts programmable wait states, range-checks and byte-lane-checks each access, and returns read data with a valid pulse or a write acknowledge with an ack pulse. It is the memory-side model used both in the SoC top and as the formally constrained memory partner of the core.

---
 rtl/svx32_mem_pkg.sv | 41 ++++
 rtl/svx32_wait_cnt.sv | 47 ++++
 rtl/svx32_dmem_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_svx32_dmem_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/svx32_mem_pkg.sv
// -----------------------------------------------------------------------------
// svx32_mem_pkg
// Shared definitions for the svx32 data-memory path.
//   dmem_state_e : controller state encoding
//   BE_*         : the byte-enable patterns a legal access may use
//   be_legal()   : byte-enable / address-alignment legality check, shared by
//                  the memory controller and the core's formal assumptions
// -----------------------------------------------------------------------------
package svx32_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RDATA  = 3'd3,
        ST_RESP   = 3'd4
    } dmem_state_e;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // addr_lo is byte-address bit 1: it selects the halfword, so it must agree
    // with which halfword the enables select. Single-byte and full-word
    // enables carry no alignment constraint of their own.
    function automatic logic be_legal(input logic addr_lo, input logic [3:0] be);
        logic ok;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_W: ok = 1'b1;
            BE_H0:                            ok = ~addr_lo;
            BE_H1:                            ok = addr_lo;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/svx32_wait_cnt.sv
// -----------------------------------------------------------------------------
// svx32_wait_cnt
// 4-bit load/decrement counter used to insert wait states.
//   pil_clk      : clock, rising edge
//   pil_rst      : synchronous active-high reset (count -> 0)
//   pil_load     : load piv_load_val (has priority over decrement)
//   pil_dec      : decrement by one, saturating at zero
//   piv_load_val : value to load
//   pol_done     : count currently reads 1, i.e. this is the last wait cycle
// -----------------------------------------------------------------------------
module svx32_wait_cnt (
    input  logic       pil_clk,
    input  logic       pil_rst,
    input  logic       pil_load,
    input  logic       pil_dec,
    input  logic [3:0] piv_load_val,
    output logic       pol_done
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated value; clocked blocks use non-blocking '<=' so every flop
    // samples the pre-edge value regardless of statement order.
    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d and no
        // latch is inferred.
        cnt_d = cnt_q;
        if (pil_load) begin
            cnt_d = piv_load_val;
        end else if (pil_dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge pil_clk) begin
        if (pil_rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pol_done = (cnt_q == 4'd1);

endmodule

// File: rtl/svx32_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// svx32_dmem_ctrl
// Data-memory controller between the svx32 core memory unit and a single-port
// synchronous SRAM. Accepts one outstanding request at a time, range- and
// byte-lane-checks it, optionally inserts WAIT_CYC wait states, performs one
// SRAM access and returns a one-cycle valid (read) or ack (write) pulse.
//
// Core side : pil_mem_req/wen, piv_mem_addr/wdata/byte_sel in;
//             pol_mem_valid, pol_mem_ack, pov_mem_rdata, pol_mem_err out.
// SRAM side : pol_sram_cs/we, pov_sram_addr/wdata/be out; piv_sram_rdata in
//             (valid the cycle after a read access).
// All outputs are registered. pil_rst is synchronous, active high.
// -----------------------------------------------------------------------------
module svx32_dmem_ctrl
    import svx32_mem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int          WAIT_CYC  = 0
) (
    input  logic              pil_clk,
    input  logic              pil_rst,
    input  logic              pil_mem_req,
    input  logic              pil_mem_wen,
    input  logic [31:0]       piv_mem_addr,
    input  logic [31:0]       piv_mem_wdata,
    input  logic [3:0]        piv_mem_byte_sel,
    output logic              pol_mem_valid,
    output logic              pol_mem_ack,
    output logic [31:0]       pov_mem_rdata,
    output logic              pol_mem_err,
    output logic              pol_sram_cs,
    output logic              pol_sram_we,
    output logic [ADDR_W-1:0] pov_sram_addr,
    output logic [31:0]       pov_sram_wdata,
    output logic [3:0]        pov_sram_be,
    input  logic [31:0]       piv_sram_rdata
);

    // FSM state and captured request
    dmem_state_e       state_q,   state_d;
    logic              wen_q,     wen_d;
    logic [ADDR_W-1:0] waddr_q,   waddr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [3:0]        be_q,      be_d;
    logic              cls_err_q, cls_err_d;

    // Registered outputs
    logic              valid_q,   valid_d;
    logic              ack_q,     ack_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              cs_q,      cs_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] saddr_q,   saddr_d;
    logic [31:0]       swdata_q,  swdata_d;
    logic [3:0]        sbe_q,     sbe_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_done;

    // Byte-address bit 0 carries no information for word/halfword/byte lane
    // selection; the enables already say which bytes are touched.
    logic unused_addr_b0;
    assign unused_addr_b0 = piv_mem_addr[0];

    svx32_wait_cnt u_wait_cnt (
        .pil_clk      (pil_clk),
        .pil_rst      (pil_rst),
        .pil_load     (cnt_load),
        .pil_dec      (cnt_dec),
        .piv_load_val (4'(WAIT_CYC)),
        .pol_done     (cnt_done)
    );

    always_comb begin
        state_d    = state_q;
        wen_d      = wen_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        cls_err_d  = cls_err_q;
        valid_d    = 1'b0;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        resp_err_d = 1'b0;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        saddr_d    = '0;
        swdata_d   = '0;
        sbe_d      = '0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pil_mem_req) begin
                    wen_d     = pil_mem_wen;
                    waddr_d   = piv_mem_addr[ADDR_W+1:2];
                    wdata_d   = piv_mem_wdata;
                    be_d      = piv_mem_byte_sel;
                    cls_err_d = (piv_mem_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2])
                              || !be_legal(piv_mem_addr[1], piv_mem_byte_sel);
                    if (cls_err_d) begin
                        // Rejected accesses answer immediately without touching the SRAM.
                        state_d    = ST_RESP;
                        valid_d    = ~pil_mem_wen;
                        ack_d      = pil_mem_wen;
                        resp_err_d = 1'b1;
                        if (!pil_mem_wen) begin
                            rdata_d = '0;
                        end
                    end else if (WAIT_CYC > 0) begin
                        state_d  = ST_WAIT;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wen_q) begin
                    state_d    = ST_RESP;
                    ack_d      = 1'b1;
                    resp_err_d = cls_err_q;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                // Raw word; the core extracts the addressed lanes itself.
                rdata_d    = piv_sram_rdata;
                valid_d    = 1'b1;
                resp_err_d = cls_err_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SRAM port is registered, so it is driven for the cycle we are about
        // to enter ACCESS; from IDLE with no wait states the capture happens
        // in the same cycle, hence the *_d values.
        if (state_d == ST_ACCESS) begin
            cs_d     = 1'b1;
            we_d     = wen_d;
            saddr_d  = waddr_d;
            swdata_d = wdata_d;
            sbe_d    = be_d;
        end
    end

    always_ff @(posedge pil_clk) begin
        if (pil_rst) begin
            state_q    <= ST_IDLE;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            cls_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            saddr_q    <= '0;
            swdata_q   <= '0;
            sbe_q      <= '0;
        end else begin
            state_q    <= state_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            cls_err_q  <= cls_err_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            saddr_q    <= saddr_d;
            swdata_q   <= swdata_d;
            sbe_q      <= sbe_d;
        end
    end

    assign pol_mem_valid  = valid_q;
    assign pol_mem_ack    = ack_q;
    assign pov_mem_rdata  = rdata_q;
    assign pol_mem_err    = resp_err_q;
    assign pol_sram_cs    = cs_q;
    assign pol_sram_we    = we_q;
    assign pov_sram_addr  = saddr_q;
    assign pov_sram_wdata = swdata_q;
    assign pov_sram_be    = sbe_q;

endmodule

// File: tb/tb_svx32_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_svx32_dmem_ctrl
// Two controller instances share the clock and reset: instance 0 with no wait
// states, instance 1 with WAIT_CYC=3. Each has its own behavioural SRAM.
// ADDR_W=11 with base 0x2000 gives an aligned 8 KiB region 0x2000..0x3FFF,
// so byte address 0x2010 maps to SRAM word 4 and 0x1000 lies outside.
// -----------------------------------------------------------------------------
module tb_svx32_dmem_ctrl;

    localparam int          ADDR_W = 11;
    localparam logic [31:0] BASE   = 32'h0000_2000;
    localparam int          WAIT1  = 3;

    typedef struct {
        int          d;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rdata;
        string       name;
    } vec_t;

    typedef struct {
        logic        is_wr;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req        [2];
    logic              wen        [2];
    logic [31:0]       addr       [2];
    logic [31:0]       wdata      [2];
    logic [3:0]        be         [2];
    logic              valid      [2];
    logic              ack        [2];
    logic [31:0]       rdata      [2];
    logic              err        [2];
    logic              sram_cs    [2];
    logic              sram_we    [2];
    logic [ADDR_W-1:0] sram_addr  [2];
    logic [31:0]       sram_wdata [2];
    logic [3:0]        sram_be    [2];
    logic [31:0]       sram_rdata [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] mem [2048];

        always @(posedge clk) begin
            if (sram_cs[g]) begin
                if (sram_we[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sram_be[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
                    end
                end else begin
                    sram_rdata[g] <= mem[sram_addr[g]];
                end
            end
        end

        svx32_dmem_ctrl #(
            .ADDR_W    (ADDR_W),
            .BASE_ADDR (BASE),
            .WAIT_CYC  (WAIT1 * g)
        ) u_dut (
            .pil_clk          (clk),
            .pil_rst          (rst),
            .pil_mem_req      (req[g]),
            .pil_mem_wen      (wen[g]),
            .piv_mem_addr     (addr[g]),
            .piv_mem_wdata    (wdata[g]),
            .piv_mem_byte_sel (be[g]),
            .pol_mem_valid    (valid[g]),
            .pol_mem_ack      (ack[g]),
            .pov_mem_rdata    (rdata[g]),
            .pol_mem_err      (err[g]),
            .pol_sram_cs      (sram_cs[g]),
            .pol_sram_we      (sram_we[g]),
            .pov_sram_addr    (sram_addr[g]),
            .pov_sram_wdata   (sram_wdata[g]),
            .pov_sram_be      (sram_be[g]),
            .piv_sram_rdata   (sram_rdata[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] b,
                                input logic e, input logic [31:0] rd, input string nm);
        vec_t v;
        v.d = d; v.wen = w; v.addr = a; v.wdata = wd; v.be = b;
        v.err = e; v.rdata = rd; v.name = nm;
        return v;
    endfunction

    task automatic check_zero(input int d, input string tag);
        check({tag, " valid"},      32'(valid[d]),      32'h0);
        check({tag, " ack"},        32'(ack[d]),        32'h0);
        check({tag, " err"},        32'(err[d]),        32'h0);
        check({tag, " rdata"},      rdata[d],           32'h0);
        check({tag, " sram_cs"},    32'(sram_cs[d]),    32'h0);
        check({tag, " sram_we"},    32'(sram_we[d]),    32'h0);
        check({tag, " sram_addr"},  32'(sram_addr[d]),  32'h0);
        check({tag, " sram_wdata"}, sram_wdata[d],      32'h0);
        check({tag, " sram_be"},    32'(sram_be[d]),    32'h0);
    endtask

    // Over n cycles, no response pulse and no SRAM select may appear.
    task automatic watch_quiet(input int d, input int n, input string tag);
        int events = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid[d] || ack[d] || sram_cs[d]) events++;
        end
        check({tag, " quiet"}, events, 0);
    endtask

    // Drives one request at cycle 0, follows it to its response and checks
    // the SRAM access and the response against bench-derived expectations.
    task automatic run_txn(input vec_t v, input bit keep, input bit drop);
        exp_t e;
        int   d = v.d;
        int   w = (d == 1) ? WAIT1 : 0;
        int   cyc = 0;
        int   cs_cnt = 0;
        bit   got = 1'b0;

        @(posedge clk); #1;
        req[d] = 1'b1; wen[d] = v.wen; addr[d] = v.addr; wdata[d] = v.wdata; be[d] = v.be;
        e.is_wr = v.wen;
        e.err   = v.err;
        e.rdata = v.rdata;
        e.lat   = v.err ? 1 : (v.wen ? 2 + w : 3 + w);
        sb_q.push_back(e);

        while (!got && cyc <= 40) begin
            @(negedge clk);
            if (sram_cs[d]) begin
                cs_cnt++;
                check({v.name, " cs_cycle"},   cyc, 1 + w);
                check({v.name, " sram_we"},    32'(sram_we[d]), 32'(v.wen));
                check({v.name, " sram_addr"},  32'(sram_addr[d]), (v.addr - BASE) >> 2);
                check({v.name, " sram_be"},    32'(sram_be[d]), 32'(v.be));
                check({v.name, " sram_wdata"}, sram_wdata[d], v.wdata);
            end
            if (valid[d] || ack[d]) begin
                got = 1'b1;
                check({v.name, " sb_pending"}, sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check({v.name, " latency"},   cyc, e.lat);
                    check({v.name, " both"},      32'(valid[d] & ack[d]), 32'h0);
                    check({v.name, " ack"},       32'(ack[d]), 32'(e.is_wr));
                    check({v.name, " valid"},     32'(valid[d]), 32'(!e.is_wr));
                    check({v.name, " err"},       32'(err[d]), 32'(e.err));
                    if (!e.is_wr) check({v.name, " rdata"}, rdata[d], e.rdata);
                end
            end else begin
                @(posedge clk); #1;
                cyc++;
                if (cyc == 1) begin
                    // Inputs after capture must not matter.
                    wen[d] = ~v.wen; addr[d] = $urandom; wdata[d] = $urandom;
                    be[d] = 4'($urandom);
                end
                if (drop && cyc == 2) req[d] = 1'b0;
            end
        end
        check({v.name, " responded"}, 32'(got), 32'h1);
        if (!got) sb_q.delete();
        check({v.name, " cs_count"}, cs_cnt, v.err ? 0 : 1);
        if (!keep) begin
            @(posedge clk); #1;
            req[d] = 1'b0;
            @(negedge clk);
            check({v.name, " pulse_end"}, 32'(valid[d] | ack[d] | sram_cs[d]), 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end

        // Instance 0: no wait states
        vecs.push_back(mk(0, 1, 32'h2010, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0,         "w0_word"));
        vecs.push_back(mk(0, 0, 32'h2010, 32'h0,         4'b1111, 0, 32'hDEAD_BEEF, "r0_word"));
        vecs.push_back(mk(0, 0, 32'h1000, 32'h0,         4'b1111, 1, 32'h0,         "r0_range"));
        vecs.push_back(mk(0, 0, 32'h2010, 32'h0,         4'b1111, 0, 32'hDEAD_BEEF, "r0_again"));
        vecs.push_back(mk(0, 0, 32'h2002, 32'h0,         4'b0011, 1, 32'h0,         "r0_h0_misal"));
        vecs.push_back(mk(0, 1, 32'h2010, 32'h1,         4'b0101, 1, 32'h0,         "w0_be0101"));
        vecs.push_back(mk(0, 1, 32'h2010, 32'h1,         4'b1100, 1, 32'h0,         "w0_h1_misal"));
        vecs.push_back(mk(0, 1, 32'h2013, 32'h5A00_0000, 4'b1000, 0, 32'h0,         "w0_byte3"));
        vecs.push_back(mk(0, 1, 32'h2010, 32'h0000_1234, 4'b0011, 0, 32'h0,         "w0_h0"));
        vecs.push_back(mk(0, 0, 32'h2010, 32'h0,         4'b1111, 0, 32'h5AAD_1234, "r0_merge"));
        vecs.push_back(mk(0, 1, 32'h2011, 32'h0000_7700, 4'b0010, 0, 32'h0,         "w0_byte1"));
        vecs.push_back(mk(0, 0, 32'h2010, 32'h0,         4'b1111, 0, 32'h5AAD_7734, "r0_merge2"));
        vecs.push_back(mk(0, 0, 32'h2010, 32'h0,         4'b0000, 1, 32'h0,         "r0_be0000"));
        vecs.push_back(mk(0, 1, 32'h3FFC, 32'h0BAD_F00D, 4'b1111, 0, 32'h0,         "w0_top"));
        vecs.push_back(mk(0, 0, 32'h3FFC, 32'h0,         4'b1111, 0, 32'h0BAD_F00D, "r0_top"));
        vecs.push_back(mk(0, 1, 32'h4000, 32'h1,         4'b1111, 1, 32'h0,         "w0_above"));
        vecs.push_back(mk(0, 0, 32'h1FFC, 32'h0,         4'b1111, 1, 32'h0,         "r0_below"));
        // Instance 1: three wait states
        vecs.push_back(mk(1, 1, 32'h2010, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0,         "w1_word"));
        vecs.push_back(mk(1, 1, 32'h2012, 32'hCAFE_0000, 4'b1100, 0, 32'h0,         "w1_h1"));
        vecs.push_back(mk(1, 0, 32'h2010, 32'h0,         4'b1111, 0, 32'hCAFE_BEEF, "r1_merge"));
        vecs.push_back(mk(1, 0, 32'h1000, 32'h0,         4'b1111, 1, 32'h0,         "r1_range"));
        vecs.push_back(mk(1, 0, 32'h2010, 32'h0,         4'b1111, 0, 32'hCAFE_BEEF, "r1_again"));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero(0, "reset0");
        check_zero(1, "reset1");

        foreach (vecs[i]) run_txn(vecs[i], 1'b0, 1'b0);

        // Back-to-back: req stays high through RESP, next request in the following IDLE cycle
        run_txn(mk(0, 1, 32'h2020, 32'h1122_3344, 4'b1111, 0, 32'h0,         "b2b_w"), 1'b1, 1'b0);
        run_txn(mk(0, 0, 32'h2020, 32'h0,         4'b1111, 0, 32'h1122_3344, "b2b_r"), 1'b0, 1'b0);

        // req dropped during WAIT: still exactly one response
        run_txn(mk(1, 1, 32'h2030, 32'h5566_7788, 4'b1111, 0, 32'h0,         "drop_w"), 1'b0, 1'b1);
        run_txn(mk(1, 0, 32'h2030, 32'h0,         4'b1111, 0, 32'h5566_7788, "drop_r"), 1'b0, 1'b1);

        // Reset while instance 1 sits in WAIT (cycles 1..3)
        @(posedge clk); #1;
        req[1] = 1'b1; wen[1] = 1'b0; addr[1] = 32'h2030; be[1] = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req[1] = 1'b0;
        @(negedge clk);
        check_zero(1, "rst_wait");
        watch_quiet(1, 10, "rst_wait");
        run_txn(mk(1, 0, 32'h2030, 32'h0, 4'b1111, 0, 32'h5566_7788, "after_rst_wait"), 1'b0, 1'b0);

        // Reset while instance 0 is in ACCESS (cycle 1)
        @(posedge clk); #1;
        req[0] = 1'b1; wen[0] = 1'b0; addr[0] = 32'h2020; be[0] = 4'b1111;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_access cs_before", 32'(sram_cs[0]), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        check_zero(0, "rst_access");
        watch_quiet(0, 10, "rst_access");
        run_txn(mk(0, 0, 32'h2020, 32'h0, 4'b1111, 0, 32'h1122_3344, "after_rst_access"), 1'b0, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
